// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS multiply/divide unit with private HI/LO
//
// Purpose: runs MULT/MULTU/DIV/DIVU over WIDTH iterations into HI/LO and
// services MTHI/MTLO writes while idle.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start, op    launch (idle only); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B         register-file read data 1/2 (sampled only on the start edge)
//   HIWr, LOWr   MTHI/MTLO: write A into HI/LO (idle, no start)
//   busy, done   stall request; one-cycle result-valid pulse
//   HI, LO       result registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIWr,
    input  logic             LOWr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;       // result (product/quotient) negated
    logic               sa_q, sa_d;         // remainder negated
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;   // raw A, only needed for divide by zero
    logic [WIDTH-1:0]   b_q, b_d;           // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial/remainder, multiplier/quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes for the launch edge
    logic               is_signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign is_signed_op = ~op[0];
    assign a_neg        = is_signed_op & A[WIDTH-1];
    assign b_neg        = is_signed_op & B[WIDTH-1];
    assign a_mag        = a_neg ? (~A + 1'b1) : A;
    assign b_mag        = b_neg ? (~B + 1'b1) : B;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right (carry in).
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder and
    // subtract when it fits. The remainder stays below the divisor, so the
    // modular WIDTH-bit subtraction is exact.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Sign correction for the FIX edge
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fixed  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fixed  = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        div0_d   = div0_q;
        a_raw_d  = a_raw_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    count_d  = '0;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    sa_d     = op[1] & a_neg;
                    div0_d   = op[1] & (B == '0);
                    a_raw_d  = A;
                    if (op[1]) begin
                        b_d   = b_mag;
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        b_d   = a_mag;
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                    end
                end else begin
                    if (HIWr) hi_d = A;
                    if (LOWr) lo_d = A;
                end
            end
            S_CALC: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            div0_q   <= 1'b0;
            a_raw_q  <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            div0_q   <= div0_d;
            a_raw_q  <= a_raw_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        HIWr, LOWr;
    logic        busy, done;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .HIWr(HIWr), .LOWr(LOWr), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: MIPS semantics from plain integer arithmetic, returns {HI, LO}
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: begin
                q = sa * sb;
                return q;
            end
            2'b01: begin
                p = ua * ub;
                return p;
            end
            default: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
        return $urandom;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input bit mt_at_start);
        int n;
        logic [63:0] r;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        HIWr = mt_at_start; LOWr = mt_at_start;
        @(negedge clk);
        start = 1'b0; HIWr = 1'b0; LOWr = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (disturb) begin
                A = $urandom; B = $urandom; op = 2'($urandom);
                start = 1'($urandom); HIWr = 1'($urandom); LOWr = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0; HIWr = 1'b0; LOWr = 1'b0;
        r = ref_model(o, a, b);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check({tag, " busy_cycles"}, 64'(n), 64'd33);
        check({tag, " done"}, {63'b0, done}, 64'd1);
        check({tag, " HI"}, {32'b0, HI}, {32'b0, exp_hi});
        check({tag, " LO"}, {32'b0, LO}, {32'b0, exp_lo});
        @(negedge clk);
        check({tag, " done_drop"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        bit seen_done;
        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0; HIWr = 1'b0; LOWr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        check("reset HI", {32'b0, HI}, 64'd0);
        check("reset LO", {32'b0, LO}, 64'd0);

        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        check("mult_neg3x7 const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max const", {HI, LO}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op("mult_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("mult_m1m1 const", {HI, LO}, {32'h0, 32'h1});
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_m7_2 const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_by0", 2'b11, 32'h1234, 32'h0, 1'b0, 1'b0);
        check("divu_by0 const", {HI, LO}, {32'h0000_1234, 32'hFFFF_FFFF});
        run_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'h0, 1'b0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf const", {HI, LO}, {32'h0, 32'h8000_0000});

        // Reset mid-calculation aborts without a result
        @(negedge clk);
        op = 2'b01; A = 32'd5; B = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("abort busy", {63'b0, busy}, 64'd0);
        check("abort HI", {32'b0, HI}, 64'd0);
        check("abort LO", {32'b0, LO}, 64'd0);
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort no_done", {63'b0, seen_done}, 64'd0);
        run_op("multu_5x6", 2'b01, 32'd5, 32'd6, 1'b0, 1'b0);
        check("multu_5x6 const", {HI, LO}, {32'h0, 32'd30});

        // MTHI / MTLO in idle
        @(negedge clk);
        A = 32'hDEAD_BEEF; HIWr = 1'b1;
        @(negedge clk);
        HIWr = 1'b0;
        exp_hi = 32'hDEAD_BEEF;
        check("mthi HI", {32'b0, HI}, {32'b0, exp_hi});
        check("mthi LO", {32'b0, LO}, {32'b0, exp_lo});
        A = 32'h0BAD_F00D; LOWr = 1'b1;
        @(negedge clk);
        LOWr = 1'b0;
        exp_lo = 32'h0BAD_F00D;
        check("mtlo HI", {32'b0, HI}, {32'b0, exp_hi});
        check("mtlo LO", {32'b0, LO}, {32'b0, exp_lo});
        A = 32'h1357_9BDF; HIWr = 1'b1; LOWr = 1'b1;
        @(negedge clk);
        HIWr = 1'b0; LOWr = 1'b0;
        check("mtboth", {HI, LO}, {32'h1357_9BDF, 32'h1357_9BDF});

        // Inputs during busy and MT writes alongside start are ignored
        run_op("disturb_mult", 2'b00, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1);
        run_op("disturb_divu", 2'b11, 32'hFFFF_0000, 32'd13, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rand%0d", i), 2'($urandom), ra, rb, bit'(i % 3 == 0), bit'(i % 5 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit sitting directly downstream of the register file read ports. Its operand inputs are driven by register-file read data 1 and 2. It executes MIPS MULT/MULTU/DIV/DIVU into private HI/LO registers and supports MTHI/MTLO writes. HI/LO outputs feed the MFHI/MFLO write-back mux; busy feeds the pipeline stall logic.

Parameters:
WIDTH, 32, operand/HI/LO width; also the number of CALC iterations.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  launch operation selected by op; honoured only when busy=0.
op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
A  in  WIDTH  operand A, driven by register-file read data 1; dividend / multiplicand / MTHI-MTLO data.
B  in  WIDTH  operand B, driven by register-file read data 2; divisor / multiplier.
HIWr  in  1  MTHI: write A into HI.
LOWr  in  1  MTLO: write A into LO.
busy  out  1  operation in progress.
done  out  1  one-cycle pulse; new HI/LO are valid this cycle.
HI  out  WIDTH  HI register (product high half / remainder).
LO  out  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset is synchronous and active-high. At a clk edge with rst=1: state=IDLE, HI=0, LO=0, busy=0, done=0, iteration counter=0. Any in-flight operation is aborted with no HI/LO update. rst has priority over all other inputs.
- States:
  - IDLE: busy=0. At an edge with start=1:
    - latch op and sign flags.
    - latch |A| and |B| for signed ops; latch raw A and B for unsigned ops.
    - go to CALC with count=0.
  - CALC: busy=1. One iteration per edge; count increments. After WIDTH iterations go to FIX.
    - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
    - Divide: restoring, one quotient bit per edge.
  - FIX: busy=1. At the edge:
    - apply sign correction.
    - write HI/LO.
    - set done=1.
    - return to IDLE.
- Latency: start sampled at edge e0. busy is high from after e0 through e(WIDTH+1), i.e. WIDTH+1 cycles. HI/LO are updated and done=1 in the cycle following edge e(WIDTH+1); busy=0 in that same cycle.
- done is high for exactly one cycle and is 0 otherwise.
- A, B and op are ignored after the start edge; changes during CALC/FIX have no effect.
- start while busy=1: ignored, not queued.
- HIWr/LOWr:
  - Effective only in IDLE with start=0; take effect at that edge. HIWr and LOWr together write A into both HI and LO.
  - While busy, or in the same cycle as an accepted start: ignored.
  - start has priority over HIWr/LOWr.
- Sign rules:
  - Product is negated (2*WIDTH two's complement) when the operand signs differ.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - Unsigned ops apply no correction.
- Divide by zero (B=0, DIV or DIVU): HI=A as sampled, LO=all ones. Latency is unchanged.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV): LO=0x80000000, HI=0. Wrap, no trap.
- HI/LO hold their values indefinitely except on FIX, HIWr/LOWr, or rst.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7: busy high 33 cycles, then done pulses once. HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. Repeat with MULT: HI=0, LO=1.
- DIV A=0xFFFFFFF9 (-7), B=2: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU A=0x1234, B=0: HI=0x00001234, LO=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Start MULTU 5*6, assert rst at CALC cycle 10:
  - next cycle: busy=0, HI=LO=0, and no done at cycle 34.
  - a subsequent start computes HI=0, LO=30.
- HIWr=1 with A=0xDEADBEEF in IDLE: HI=0xDEADBEEF, LO unchanged.
- During busy: HIWr, LOWr and start have no effect, and the final HI/LO equal the original op's result.
